// File: rtl/pwm_capture_pkg.sv
// Shared definitions for the PWM capture block: FSM state encoding.
// Encodings match the PWM generator so that both sides decode state dumps alike.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_MEASURE = 2'd1,
        ST_STALLED = 2'd2
    } cap_state_t;

endpackage

// File: rtl/pwm_capture_input_sync.sv
// PWM input front end: synchroniser, optional glitch filter, rising-edge detector.
// Optional filter enabled by defining PWM_CAPTURE_FILTER_EN.
module pwm_capture_input_sync #(
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic clk,
    input  logic rst,
    input  logic pwm_in,
    output logic lvl,
    output logic rise
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   synced;
    logic                   lvl_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sync_q <= '0;
        else     sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
    end

    assign synced = sync_q[SYNC_STAGES-1];

`ifdef PWM_CAPTURE_FILTER_EN
    localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;

    logic [FW-1:0] stable_cnt;
    logic          lvl_q;

    // Level flips only after the synced input has disagreed for FILTER_LEN cycles in a row.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lvl_q      <= 1'b0;
            stable_cnt <= '0;
        end else if (synced != lvl_q) begin
            if (stable_cnt == FW'(FILTER_LEN - 1)) begin
                lvl_q      <= synced;
                stable_cnt <= '0;
            end else begin
                stable_cnt <= stable_cnt + FW'(1);
            end
        end else begin
            stable_cnt <= '0;
        end
    end

    assign lvl = lvl_q;
`else
    // FILTER_LEN only matters when the filter is built in.
    logic unused_filter_cfg;
    assign unused_filter_cfg = (FILTER_LEN > 0);
    assign lvl = synced;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) lvl_d <= 1'b0;
        else     lvl_d <= lvl;
    end

    assign rise = lvl & ~lvl_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures period and high time between rising edges, flags a stuck line.
// Build option PWM_CAPTURE_FILTER_EN adds a FILTER_LEN-cycle glitch filter on the input.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_WIDTH   = 16,
    parameter int SYNC_STAGES = 2,
    parameter int FILTER_LEN  = 3
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 pwm_in,
    output logic [CNT_WIDTH-1:0] period_out,
    output logic [CNT_WIDTH-1:0] high_out,
    output logic                 meas_valid,
    output logic                 timeout,
    output logic                 level_out
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    cap_state_t           state, state_n;
    logic [CNT_WIDTH-1:0] pcnt, pcnt_n;
    logic [CNT_WIDTH-1:0] hcnt, hcnt_n;
    logic [CNT_WIDTH-1:0] period_n, high_n;
    logic                 valid_n, timeout_n;
    logic                 lvl, rise;

    pwm_capture_input_sync #(
        .SYNC_STAGES (SYNC_STAGES),
        .FILTER_LEN  (FILTER_LEN)
    ) u_input_sync (
        .clk    (clk),
        .rst    (rst),
        .pwm_in (pwm_in),
        .lvl    (lvl),
        .rise   (rise)
    );

    assign level_out = lvl;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= ST_IDLE;
            pcnt       <= '0;
            hcnt       <= '0;
            period_out <= '0;
            high_out   <= '0;
            meas_valid <= 1'b0;
            timeout    <= 1'b0;
        end else begin
            state      <= state_n;
            pcnt       <= pcnt_n;
            hcnt       <= hcnt_n;
            period_out <= period_n;
            high_out   <= high_n;
            meas_valid <= valid_n;
            timeout    <= timeout_n;
        end
    end

    always_comb begin
        state_n   = state;
        pcnt_n    = pcnt;
        hcnt_n    = hcnt;
        period_n  = period_out;
        high_n    = high_out;
        valid_n   = 1'b0;
        timeout_n = timeout;
        unique case (state)
            ST_IDLE: begin
                if (rise) begin
                    state_n = ST_MEASURE;
                    pcnt_n  = CNT_WIDTH'(1);
                    hcnt_n  = CNT_WIDTH'(1);
                end
            end
            ST_MEASURE: begin
                if (rise) begin
                    period_n = pcnt;
                    high_n   = hcnt;
                    valid_n  = 1'b1;
                    pcnt_n   = CNT_WIDTH'(1);
                    hcnt_n   = CNT_WIDTH'(1);
                end else if (pcnt == CNT_MAX) begin
                    // Line stuck: report a saturated period instead of wrapping.
                    state_n   = ST_STALLED;
                    valid_n   = 1'b1;
                    period_n  = CNT_MAX;
                    high_n    = lvl ? CNT_MAX : '0;
                    timeout_n = 1'b1;
                end else begin
                    pcnt_n = pcnt + CNT_WIDTH'(1);
                    hcnt_n = hcnt + CNT_WIDTH'(lvl);
                end
            end
            ST_STALLED: begin
                // The partial period ending at this edge is never reported.
                if (rise) begin
                    state_n   = ST_MEASURE;
                    pcnt_n    = CNT_WIDTH'(1);
                    hcnt_n    = CNT_WIDTH'(1);
                    timeout_n = 1'b0;
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_pwm_capture.sv
// Self-checking bench for pwm_capture: waveform tables and random periods checked
// against an edge-list reference model; CNT_WIDTH=8 keeps stall scenarios short.
module tb_pwm_capture;

    localparam int CW   = 8;
    localparam int SS   = 2;
    localparam int FL   = 3;
    localparam int MAXV = (1 << CW) - 1;
    localparam int LAT  = SS + 1;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int MFL = FL;
`else
    localparam int MFL = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          pwm_in = 1'b0;
    logic [CW-1:0] period_out, high_out;
    logic          meas_valid, timeout, level_out;

    int checks = 0;
    int errors = 0;
    int wave[$];

    pwm_capture #(
        .CNT_WIDTH   (CW),
        .SYNC_STAGES (SS),
        .FILTER_LEN  (FL)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .pwm_in     (pwm_in),
        .period_out (period_out),
        .high_out   (high_out),
        .meas_valid (meas_valid),
        .timeout    (timeout),
        .level_out  (level_out)
    );

    always #5 clk = ~clk;

    task automatic add_const(input int v, input int n);
        repeat (n) wave.push_back(v);
    endtask

    task automatic add_period(input int p, input int h);
        add_const(1, h);
        add_const(0, p - h);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst    = 1'b1;
        pwm_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic check_zero(input string tag);
        checks++;
        if ({period_out, high_out, meas_valid, timeout, level_out} !== '0) begin
            errors++;
            $display("FAIL %s outputs not zero: period=%0d high=%0d valid=%b timeout=%b level=%b, expected all 0",
                     tag, period_out, high_out, meas_valid, timeout, level_out);
        end
    endtask

    // Reference model: filtered level list -> rising-edge list -> measurements,
    // stalls and timeout intervals; then drive the wave and compare every cycle.
    task automatic run_check(input string tag);
        int n, a, s, b, hsum;
        bit started, stalled, all_diff;
        int f[], e_mv[], e_p[], e_h[], e_to[];
        int rises[$];
        n    = wave.size();
        f    = new[n];
        e_mv = new[n];
        e_p  = new[n];
        e_h  = new[n];
        e_to = new[n];
        for (int i = 0; i < n; i++) begin
            if (MFL == 0) begin
                f[i] = wave[i];
            end else begin
                int prev;
                prev     = (i > 0) ? f[i-1] : 0;
                all_diff = 1'b1;
                for (int j = i - MFL; j < i; j++)
                    if (((j >= 0) ? wave[j] : 0) == prev) all_diff = 1'b0;
                f[i] = all_diff ? 1 - prev : prev;
            end
        end
        for (int i = 0; i < n; i++)
            if (f[i] == 1 && (i == 0 || f[i-1] == 0)) rises.push_back(i);

        started = 1'b0;
        stalled = 1'b0;
        a       = 0;
        for (int r = 0; r <= rises.size(); r++) begin
            b = (r < rises.size()) ? rises[r] : n + MAXV + 1;
            if (started && !stalled && b - a > MAXV) begin
                s = a + MAXV;
                if (s + LAT < n) begin
                    e_mv[s+LAT] = 1;
                    e_p[s+LAT]  = MAXV;
                    e_h[s+LAT]  = f[s] ? MAXV : 0;
                end
                for (int k = s + LAT; k < n; k++) e_to[k] = 1;
                stalled = 1'b1;
            end
            if (r == rises.size()) break;
            if (!started) begin
                started = 1'b1;
            end else if (stalled) begin
                stalled = 1'b0;
                for (int k = b + LAT; k < n; k++) e_to[k] = 0;
            end else if (b + LAT < n) begin
                hsum = 0;
                for (int k = a; k < b; k++) hsum += f[k];
                e_mv[b+LAT] = 1;
                e_p[b+LAT]  = b - a;
                e_h[b+LAT]  = hsum;
            end
            a = b;
        end

        for (int k = 0; k < n; k++) begin
            logic exp_lvl;
            @(negedge clk);
            exp_lvl = (k >= SS) ? (f[k-SS] != 0) : 1'b0;
            checks++;
            if (meas_valid !== (e_mv[k] != 0)) begin
                errors++;
                $display("FAIL %s meas_valid at sample %0d: got %b expected %b", tag, k, meas_valid, e_mv[k] != 0);
            end
            checks++;
            if (timeout !== (e_to[k] != 0)) begin
                errors++;
                $display("FAIL %s timeout at sample %0d: got %b expected %b", tag, k, timeout, e_to[k] != 0);
            end
            checks++;
            if (level_out !== exp_lvl) begin
                errors++;
                $display("FAIL %s level_out at sample %0d: got %b expected %b", tag, k, level_out, exp_lvl);
            end
            if (e_mv[k] != 0) begin
                checks++;
                if (period_out !== CW'(e_p[k])) begin
                    errors++;
                    $display("FAIL %s period_out at sample %0d: got %0d expected %0d", tag, k, period_out, e_p[k]);
                end
                checks++;
                if (high_out !== CW'(e_h[k])) begin
                    errors++;
                    $display("FAIL %s high_out at sample %0d: got %0d expected %0d", tag, k, high_out, e_h[k]);
                end
            end
            pwm_in = (wave[k] != 0);
        end
        wave.delete();
    endtask

    task automatic test_reset();
        #2 rst = 1'b1;
        #1 check_zero("reset_async");
        repeat (2) @(negedge clk);
        check_zero("reset_held");
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_reset();
        add_const(0, 10);
        repeat (5) add_period(100, 25);
        add_const(0, 10);
        run_check("basic_100_25");
    endtask

    task automatic test_duty_sweep();
        do_reset();
        add_const(0, 5);
        repeat (2) add_period(100, 25);
        for (int d = 0; d <= 100; d += 10) repeat (3) add_period(100, d);
        repeat (3) add_period(100, 50);
        add_const(0, 10);
        run_check("duty_sweep");
    endtask

    task automatic test_stall();
        do_reset();
        add_const(0, 5);
        add_period(10, 3);
        add_const(0, 300);
        add_const(1, 300);
        add_const(0, 20);
        repeat (3) add_period(50, 20);
        add_period(MAXV, 100);
        add_period(MAXV + 1, 100);
        repeat (3) add_period(40, 10);
        add_const(0, 10);
        run_check("stall");
    endtask

    task automatic test_random();
        int p;
        do_reset();
        add_const(0, 7);
        repeat (25) begin
            p = $urandom_range(2, 300);
            add_period(p, $urandom_range(0, p));
        end
        add_period(60, 30);
        add_const(0, 10);
        run_check("random");
    endtask

    task automatic test_async_reset();
        do_reset();
        add_const(0, 3);
        repeat (2) add_period(100, 25);
        add_const(1, 25);
        add_const(0, 25);
        run_check("pre_reset");
        @(negedge clk);
        rst = 1'b1;
        #1 check_zero("mid_period_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        add_const(0, 50);
        repeat (3) add_period(100, 25);
        add_const(0, 10);
        run_check("post_reset");
    endtask

    task automatic test_glitch();
        do_reset();
        add_const(0, 3);
        add_period(100, 25);
        add_const(1, 25);
        add_const(0, 35);
        add_const(1, 1);
        add_const(0, 39);
        repeat (2) add_period(100, 25);
        add_const(0, 10);
        run_check("glitch");
    endtask

    task automatic test_async_edges();
        int pulses;
        pulses = 0;
        do_reset();
        fork
            begin
                #3;
                repeat (12) begin
                    pwm_in = 1'b1;
                    #250;
                    pwm_in = 1'b0;
                    #753;
                end
            end
            begin
                repeat (1200) begin
                    @(negedge clk);
                    checks++;
                    if ($isunknown({period_out, high_out, meas_valid, timeout, level_out})) begin
                        errors++;
                        $display("FAIL async_x unknown output: period=%b high=%b valid=%b", period_out, high_out, meas_valid);
                    end
                    if (meas_valid === 1'b1) begin
                        pulses++;
                        checks++;
                        if (period_out != 100 && period_out != 101) begin
                            errors++;
                            $display("FAIL async_period got %0d expected 100 or 101", period_out);
                        end
                        checks++;
                        if (high_out < 24 || high_out > 26) begin
                            errors++;
                            $display("FAIL async_high got %0d expected 24..26", high_out);
                        end
                    end
                end
            end
        join
        checks++;
        if (pulses < 10) begin
            errors++;
            $display("FAIL async_pulse_count got %0d expected at least 10", pulses);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_duty_sweep();
        test_stall();
        test_random();
        test_async_reset();
        test_glitch();
        test_async_edges();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
